// File: rtl/signal_mavg_if.sv
// Sample stream bundle: signed data plus a valid strobe (no backpressure).
interface signal_mavg_if #(
  parameter int W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/signal_mavg.sv
// Boxcar moving average over the last 2^k samples, running-sum based.
// Stage 1 updates window state; stage 2 forms the output sample.
// The output is the raw sample until the window holds N samples.
module signal_mavg #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LOG2_MAX_N       = 6,
  parameter int SUM_WIDTH        = AXIS_TDATA_WIDTH + LOG2_MAX_N
) (
  input  logic                 aclk,
  input  logic                 reset,
  signal_mavg_if.slave         S_AXIS,
  input  logic [3:0]           log2_n,
  input  logic                 enable,
  signal_mavg_if.master        M_AXIS,
  output logic [SUM_WIDTH-1:0] mon_sum,
  output logic                 status_filled
);
  localparam int W     = AXIS_TDATA_WIDTH;
  localparam int DEPTH = 1 << LOG2_MAX_N;
  localparam int AW    = LOG2_MAX_N;
  localparam int CW    = LOG2_MAX_N + 1;

  logic signed [W-1:0]         mem_q [DEPTH];
  logic [AW-1:0]               wptr_q, wptr_b, wptr_d;
  logic [CW-1:0]               cnt_q, cnt_b, cnt_d;
  logic signed [SUM_WIDTH-1:0] sum_q, sum_b, sum_d;
  logic [3:0]                  k_q, k_eff;
  logic [CW-1:0]               n_eff;
  logic signed [W-1:0]         x, old, x_q;
  logic                        flush, take, filled_q, vld1_q;
  logic [W-1:0]                tdata_q;
  logic                        tvalid_q;

  assign x     = $signed(S_AXIS.tdata);
  assign k_eff = (log2_n > 4'(LOG2_MAX_N)) ? 4'(LOG2_MAX_N) : log2_n;
  assign n_eff = CW'(1) << k_eff;
  assign flush = !enable || (k_eff != k_q);
  assign take  = S_AXIS.tvalid && enable;

  // Next window state: flush first, then fold in the accepted sample.
  always_comb begin
    wptr_b = flush ? '0 : wptr_q;
    cnt_b  = flush ? '0 : cnt_q;
    sum_b  = flush ? '0 : sum_q;
    // With N equal to the depth the evicted slot is the one about to be written.
    old    = (cnt_b == n_eff) ? mem_q[wptr_b - AW'(n_eff)] : '0;
    wptr_d = wptr_b;
    cnt_d  = cnt_b;
    sum_d  = sum_b;
    if (take) begin
      wptr_d = wptr_b + AW'(1);
      cnt_d  = (cnt_b == n_eff) ? cnt_b : cnt_b + CW'(1);
      sum_d  = sum_b + SUM_WIDTH'(x) - SUM_WIDTH'(old);
    end
  end

  // Sample buffer; stale entries are fenced off by the fill counter, so no reset.
  always_ff @(posedge aclk) begin
    if (take) mem_q[wptr_b] <= x;
  end

  // Stage 1: window state, captured sample and filled flag.
  always_ff @(posedge aclk) begin
    if (reset) begin
      wptr_q   <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      k_q      <= k_eff;
      x_q      <= '0;
      filled_q <= 1'b0;
      vld1_q   <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      k_q      <= k_eff;
      filled_q <= enable && (cnt_d == n_eff);
      vld1_q   <= S_AXIS.tvalid;
      if (S_AXIS.tvalid) x_q <= x;
    end
  end

  // Stage 2: average (floor via arithmetic shift) or pass-through; holds when idle.
  always_ff @(posedge aclk) begin
    if (reset) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      tvalid_q <= vld1_q;
      if (vld1_q) tdata_q <= filled_q ? W'(sum_q >>> k_q) : x_q;
    end
  end

  assign M_AXIS.tdata   = tdata_q;
  assign M_AXIS.tvalid  = tvalid_q;
  assign mon_sum        = sum_q;
  assign status_filled  = filled_q;
endmodule

// File: tb/tb_signal_mavg.sv
// Bench for signal_mavg: queue-based window model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_signal_mavg;
  localparam int W  = 32;
  localparam int LM = 6;
  localparam int SW = W + LM;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic [3:0]    log2_n = 4'd2;
  logic [SW-1:0] mon_sum;
  logic          status_filled;

  signal_mavg_if #(.W(W)) s_if ();
  signal_mavg_if #(.W(W)) m_if ();

  signal_mavg #(.AXIS_TDATA_WIDTH(W), .LOG2_MAX_N(LM), .SUM_WIDTH(SW)) u_dut (
    .aclk          (aclk),
    .reset         (reset),
    .S_AXIS        (s_if),
    .log2_n        (log2_n),
    .enable        (enable),
    .M_AXIS        (m_if),
    .mon_sum       (mon_sum),
    .status_filled (status_filled)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  longint outs[$];

  task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint at(int i);
    return (i < outs.size()) ? outs[i] : -64'sd999999;
  endfunction

  // ---------------- model ----------------
  int     win[$];
  int     kq, ke, nn;
  longint m_sum, s;
  bit     m_filled, p_v, o_v;
  int     p_d, o_d;

  function automatic int keff(logic [3:0] l);
    return (int'(l) > LM) ? LM : int'(l);
  endfunction

  function automatic longint fdiv(longint a, longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  always @(posedge aclk) begin
    if (reset) begin
      win.delete();
      kq = keff(log2_n);
      m_sum = 0; m_filled = 0;
      p_v = 0; o_v = 0; o_d = 0; p_d = 0;
    end else begin
      ke = keff(log2_n);
      nn = 1 << ke;
      o_v = p_v;
      if (p_v) o_d = p_d;
      if (!enable || ke != kq) win.delete();
      kq = ke;
      p_v = s_if.tvalid;
      if (s_if.tvalid && enable) begin
        win.push_back($signed(s_if.tdata));
        if (win.size() > nn) void'(win.pop_front());
      end
      s = 0;
      foreach (win[i]) s += win[i];
      m_sum = s;
      m_filled = enable && (win.size() == nn);
      if (s_if.tvalid) p_d = m_filled ? int'(fdiv(s, nn)) : $signed(s_if.tdata);
    end
  end

  // Per-cycle comparison against the model, and output capture.
  always @(negedge aclk) begin
    if (chk_en) begin
      chk("tvalid",  m_if.tvalid, o_v);
      chk("tdata",   $signed(m_if.tdata), o_d);
      chk("mon_sum", $signed(mon_sum), m_sum);
      chk("filled",  status_filled, m_filled);
      if (m_if.tvalid) outs.push_back($signed(m_if.tdata));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(int x);
    @(negedge aclk);
    s_if.tvalid = 1'b1;
    s_if.tdata  = x;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge aclk);
      s_if.tvalid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    reset = 1'b1;
    s_if.tvalid = 1'b0;
    @(negedge aclk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    repeat (2) @(negedge aclk);
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tdata",  $signed(m_if.tdata), 0);
    chk("rst_sum",    $signed(mon_sum), 0);
    chk("rst_filled", status_filled, 0);

    // Fill with constant 100, k=2
    outs.delete();
    repeat (3) send(100);
    idle(1);
    chk("fill_3_filled", status_filled, 0);
    chk("fill_3_sum", $signed(mon_sum), 300);
    repeat (5) send(100);
    idle(3);
    chk("fill_count", outs.size(), 8);
    for (int i = 0; i < 8; i++) chk("fill_out", at(i), 100);
    chk("fill_sum", $signed(mon_sum), 400);
    chk("fill_filled", status_filled, 1);
    chk("model_fill_sum", m_sum, 400);

    // Step 20 -> 15
    repeat (4) send(20);
    idle(3);
    outs.delete();
    repeat (5) send(15);
    idle(3);
    chk("step0", at(0), 18);
    chk("step1", at(1), 17);
    chk("step2", at(2), 16);
    chk("step3", at(3), 15);
    chk("step4", at(4), 15);
    chk("step_sum", $signed(mon_sum), 60);

    // Negative values round toward -inf
    do_reset();
    outs.delete();
    for (int v = 1; v <= 4; v++) send(-v);
    idle(3);
    chk("neg_pass", at(0), -1);
    chk("neg_floor", at(3), -3);
    chk("neg_sum", $signed(mon_sum), -10);

    // Window change 2 -> 3 together with a valid sample
    outs.delete();
    @(negedge aclk);
    log2_n = 4'd3;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 10;
    @(negedge aclk);
    chk("kchg_drop", status_filled, 0);
    s_if.tdata = 11;
    for (int v = 12; v <= 17; v++) send(v);
    idle(3);
    chk("kchg_count", outs.size(), 8);
    chk("kchg_pass0", at(0), 10);
    chk("kchg_pass6", at(6), 16);
    chk("kchg_avg", at(7), 13);
    chk("kchg_sum", $signed(mon_sum), 108);

    // Gapped ramp with k=6, buffer wraps
    do_reset();
    log2_n = 4'd6;
    outs.delete();
    for (int i = 0; i < 200; i++) begin
      send(i);
      idle(2);
    end
    idle(3);
    chk("ramp_count", outs.size(), 200);
    chk("ramp_pass62", at(62), 62);
    chk("ramp_first", at(63), 31);
    chk("ramp_last", at(199), 167);
    chk("ramp_sum", $signed(mon_sum), 10720);
    chk("model_ramp_sum", m_sum, 10720);

    // Clamp: log2_n=9 acts as 6
    do_reset();
    log2_n = 4'd9;
    repeat (63) send(5);
    idle(1);
    chk("clamp_63", status_filled, 0);
    send(5);
    idle(1);
    chk("clamp_64", status_filled, 1);
    chk("clamp_sum", $signed(mon_sum), 320);

    // Bypass
    enable = 1'b0;
    idle(1);
    outs.delete();
    send(7); send(-8); send(9);
    idle(3);
    chk("byp0", at(0), 7);
    chk("byp1", at(1), -8);
    chk("byp2", at(2), 9);
    chk("byp_filled", status_filled, 0);
    chk("byp_sum", $signed(mon_sum), 0);
    enable = 1'b1;

    // Reset mid-window
    log2_n = 4'd2;
    send(1); send(2); send(3);
    @(negedge aclk);
    reset = 1'b1;
    s_if.tdata = 4;
    @(negedge aclk);
    reset = 1'b0;
    s_if.tvalid = 1'b0;
    #1;
    chk("mrst_tvalid", m_if.tvalid, 0);
    chk("mrst_tdata", $signed(m_if.tdata), 0);
    chk("mrst_sum", $signed(mon_sum), 0);
    idle(1);
    chk("mrst_nopulse", m_if.tvalid, 0);
    outs.delete();
    repeat (3) send(8);
    idle(1);
    chk("refill_3", status_filled, 0);
    chk("refill_sum3", $signed(mon_sum), 24);
    send(8);
    idle(3);
    chk("refill_4", status_filled, 1);
    chk("refill_count", outs.size(), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
